// File: rtl/fb_frame_sequencer.sv
// Write-domain sequencer for the SRAM double framebuffer: gates renderer writes,
// waits for vblank after frame-done, then pulses swap. Define FB_CLEAR_EN to add the back-buffer clear.
module fb_frame_sequencer #(
  parameter  int FB_WIDTH    = 160,
  parameter  int FB_HEIGHT   = 120,
  parameter  int SYNC_STAGES = 2,
  localparam int XW          = $clog2(FB_WIDTH),
  localparam int YW          = $clog2(FB_HEIGHT)
) (
  input  logic          clk_write,
  input  logic          rst,
  input  logic          vblank_rd,
  input  logic          render_we,
  input  logic [XW-1:0] render_x,
  input  logic [YW-1:0] render_y,
  input  logic [11:0]   render_data,
  input  logic          render_done,
  input  logic [11:0]   fill_color,
  output logic          render_ready,
  output logic          fb_we,
  output logic [XW-1:0] fb_x,
  output logic [YW-1:0] fb_y,
  output logic [11:0]   fb_data,
  output logic          fb_swap,
  output logic [7:0]    frame_count
);

  localparam logic [XW:0]   X_LIM  = (XW+1)'(FB_WIDTH);
  localparam logic [YW:0]   Y_LIM  = (YW+1)'(FB_HEIGHT);

  typedef enum logic [1:0] {
    S_RENDER  = 2'd0,
    S_WAIT_VB = 2'd1,
    S_SWAP    = 2'd2,
    S_CLEAR   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_n;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                 r_vb_prev;
  logic                 w_vb_sync;
  logic                 w_vb_rise;
  logic                 w_in_range;

  logic                 r_ready,   w_ready_n;
  logic                 r_fb_we,   w_fb_we_n;
  logic [XW-1:0]        r_fb_x,    w_fb_x_n;
  logic [YW-1:0]        r_fb_y,    w_fb_y_n;
  logic [11:0]          r_fb_data, w_fb_data_n;
  logic                 r_fb_swap, w_fb_swap_n;
  logic [7:0]           r_count,   w_count_n;

`ifdef FB_CLEAR_EN
  localparam logic [XW-1:0] X_LAST = XW'(FB_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FB_HEIGHT - 1);

  logic [XW-1:0]        r_clr_x,   w_clr_x_n;
  logic [YW-1:0]        r_clr_y,   w_clr_y_n;
  logic [11:0]          r_fill,    w_fill_n;
  logic                 w_clr_last;
  logic [XW-1:0]        w_clr_x_inc;
  logic [YW-1:0]        w_clr_y_inc;
`else
  logic                 w_unused_fill;
  assign w_unused_fill = ^fill_color;
`endif

  // vblank_rd is asynchronous here; only the last synchronizer flop feeds logic.
  assign w_vb_sync  = r_sync[SYNC_STAGES-1];
  assign w_vb_rise  = w_vb_sync & ~r_vb_prev;
  assign w_in_range = ({1'b0, render_x} < X_LIM) && ({1'b0, render_y} < Y_LIM);

`ifdef FB_CLEAR_EN
  assign w_clr_last  = (r_clr_x == X_LAST) && (r_clr_y == Y_LAST);
  assign w_clr_x_inc = (r_clr_x == X_LAST) ? '0 : r_clr_x + 1'b1;
  assign w_clr_y_inc = (r_clr_x == X_LAST) ? r_clr_y + 1'b1 : r_clr_y;
`endif

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    w_state_n   = r_state;
    w_fb_we_n   = 1'b0;
    w_fb_x_n    = r_fb_x;
    w_fb_y_n    = r_fb_y;
    w_fb_data_n = r_fb_data;
    w_fb_swap_n = 1'b0;
    w_count_n   = r_count;
`ifdef FB_CLEAR_EN
    w_clr_x_n   = r_clr_x;
    w_clr_y_n   = r_clr_y;
    w_fill_n    = r_fill;
`endif

    case (r_state)
      S_RENDER: begin
        if (render_we && w_in_range) begin
          w_fb_we_n   = 1'b1;
          w_fb_x_n    = render_x;
          w_fb_y_n    = render_y;
          w_fb_data_n = render_data;
        end
        if (render_done) begin
          w_state_n = S_WAIT_VB;
        end
      end

      S_WAIT_VB: begin
        if (w_vb_rise) begin
          w_state_n   = S_SWAP;
          w_fb_swap_n = 1'b1;
          w_count_n   = r_count + 8'd1;
`ifdef FB_CLEAR_EN
          w_fill_n    = fill_color;
`endif
        end
      end

      S_SWAP: begin
`ifdef FB_CLEAR_EN
        // Pixel (0,0) goes out on the cycle after the swap pulse.
        w_state_n   = S_CLEAR;
        w_fb_we_n   = 1'b1;
        w_fb_x_n    = '0;
        w_fb_y_n    = '0;
        w_fb_data_n = r_fill;
        w_clr_x_n   = '0;
        w_clr_y_n   = '0;
`else
        w_state_n   = S_RENDER;
`endif
      end

`ifdef FB_CLEAR_EN
      S_CLEAR: begin
        // Counters track the pixel currently presented on fb_*.
        if (w_clr_last) begin
          w_state_n = S_RENDER;
          w_clr_x_n = '0;
          w_clr_y_n = '0;
        end else begin
          w_fb_we_n   = 1'b1;
          w_fb_x_n    = w_clr_x_inc;
          w_fb_y_n    = w_clr_y_inc;
          w_fb_data_n = r_fill;
          w_clr_x_n   = w_clr_x_inc;
          w_clr_y_n   = w_clr_y_inc;
        end
      end
`endif

      default: begin
        w_state_n = S_RENDER;
      end
    endcase

    w_ready_n = (w_state_n == S_RENDER);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_write or posedge rst) begin
    if (rst) begin
      r_state   <= S_RENDER;
      r_sync    <= '0;
      r_vb_prev <= 1'b0;
      r_ready   <= 1'b1;
      r_fb_we   <= 1'b0;
      r_fb_x    <= '0;
      r_fb_y    <= '0;
      r_fb_data <= '0;
      r_fb_swap <= 1'b0;
      r_count   <= '0;
`ifdef FB_CLEAR_EN
      r_clr_x   <= '0;
      r_clr_y   <= '0;
      r_fill    <= '0;
`endif
    end else begin
      r_state   <= w_state_n;
      r_sync    <= {r_sync[SYNC_STAGES-2:0], vblank_rd};
      r_vb_prev <= w_vb_sync;
      r_ready   <= w_ready_n;
      r_fb_we   <= w_fb_we_n;
      r_fb_x    <= w_fb_x_n;
      r_fb_y    <= w_fb_y_n;
      r_fb_data <= w_fb_data_n;
      r_fb_swap <= w_fb_swap_n;
      r_count   <= w_count_n;
`ifdef FB_CLEAR_EN
      r_clr_x   <= w_clr_x_n;
      r_clr_y   <= w_clr_y_n;
      r_fill    <= w_fill_n;
`endif
    end
  end

  assign render_ready = r_ready;
  assign fb_we        = r_fb_we;
  assign fb_x         = r_fb_x;
  assign fb_y         = r_fb_y;
  assign fb_data      = r_fb_data;
  assign fb_swap      = r_fb_swap;
  assign frame_count  = r_count;

endmodule

// File: tb/tb_fb_frame_sequencer.sv
// Self-checking bench for fb_frame_sequencer on a 4x3 framebuffer; follows FB_CLEAR_EN
// so the same file covers both builds.
module tb_fb_frame_sequencer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int SS = 2;
`ifdef FB_CLEAR_EN
  localparam int EXP_RDY = W * H + 1;
`else
  localparam int EXP_RDY = 1;
`endif
  localparam logic [26:0] RESET_VEC = {1'b1, 1'b0, 2'd0, 2'd0, 12'd0, 1'b0, 8'd0};

  logic        clk_write = 1'b0;
  logic        rst;
  logic        vblank_rd;
  logic        render_we;
  logic [1:0]  render_x;
  logic [1:0]  render_y;
  logic [11:0] render_data;
  logic        render_done;
  logic [11:0] fill_color;
  logic        render_ready;
  logic        fb_we;
  logic [1:0]  fb_x;
  logic [1:0]  fb_y;
  logic [11:0] fb_data;
  logic        fb_swap;
  logic [7:0]  frame_count;

  int checks      = 0;
  int errors      = 0;
  int model_count = 0;

  wire [26:0] w_outs = {render_ready, fb_we, fb_x, fb_y, fb_data, fb_swap, frame_count};

  fb_frame_sequencer #(.FB_WIDTH(W), .FB_HEIGHT(H), .SYNC_STAGES(SS)) u_dut (
    .clk_write    (clk_write),
    .rst          (rst),
    .vblank_rd    (vblank_rd),
    .render_we    (render_we),
    .render_x     (render_x),
    .render_y     (render_y),
    .render_data  (render_data),
    .render_done  (render_done),
    .fill_color   (fill_color),
    .render_ready (render_ready),
    .fb_we        (fb_we),
    .fb_x         (fb_x),
    .fb_y         (fb_y),
    .fb_data      (fb_data),
    .fb_swap      (fb_swap),
    .frame_count  (frame_count)
  );

  always #5 clk_write = ~clk_write;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk_write);
    #1;
  endtask

  // Lowers vblank, lets it settle, raises it; returns cycles to swap and swap-to-ready.
  task automatic complete_swap(output int lat, output int rdy);
    vblank_rd = 1'b0;
    repeat (SS + 2) step;
    vblank_rd = 1'b1;
    lat = 0;
    do begin step; lat++; end while (fb_swap !== 1'b1 && lat < 12);
    if (fb_swap !== 1'b1) lat = -1;
    rdy = 0;
    do begin step; rdy++; end while (render_ready !== 1'b1 && rdy < 40);
    if (render_ready !== 1'b1) rdy = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1; vblank_rd = 1'b0; render_we = 1'b0; render_done = 1'b0;
    render_x = '0; render_y = '0; render_data = '0; fill_color = '0;
    repeat (2) step;
    checks++;
    if (w_outs !== RESET_VEC) begin
      errors++; $display("FAIL reset_hold got %h exp %h", w_outs, RESET_VEC);
    end
    rst = 1'b0;
    step;
    checks++;
    if (w_outs !== RESET_VEC) begin
      errors++; $display("FAIL reset_release got %h exp %h", w_outs, RESET_VEC);
    end
  endtask

  task automatic test_writes;
    logic        we;
    int          xi, yi;
    logic [11:0] d;
    logic        exp_we;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) begin
        we = 1'b1; xi = 2; yi = 1; d = 12'hABC;
      end else begin
        we = 1'($urandom_range(0, 1));
        xi = $urandom_range(0, W - 1);
        yi = $urandom_range(0, H);
        d  = 12'($urandom);
      end
      render_we = we; render_x = 2'(xi); render_y = 2'(yi); render_data = d;
      step;
      exp_we = we && (xi < W) && (yi < H);
      checks++;
      if (fb_we !== exp_we || fb_swap !== 1'b0 || render_ready !== 1'b1) begin
        errors++;
        $display("FAIL write_we[%0d] got we=%b swap=%b rdy=%b exp we=%b swap=0 rdy=1",
                 i, fb_we, fb_swap, render_ready, exp_we);
      end
      if (exp_we) begin
        checks++;
        if ({fb_x, fb_y, fb_data} !== {2'(xi), 2'(yi), d}) begin
          errors++;
          $display("FAIL write_data[%0d] got (%0d,%0d,%h) exp (%0d,%0d,%h)",
                   i, fb_x, fb_y, fb_data, xi, yi, d);
        end
      end
    end
    render_we = 1'b0;
  endtask

  task automatic test_swap;
    int          n;
    logic [11:0] fill;
    vblank_rd = 1'b0;
    repeat (SS + 2) step;
    fill = 12'h00F; fill_color = fill;
    render_done = 1'b1;
    step;
    render_done = 1'b0;
    checks++;
    if (render_ready !== 1'b0) begin
      errors++; $display("FAIL swap_ready_fall got %b exp 0", render_ready);
    end
    for (int i = 0; i < 5; i++) begin
      render_we = 1'b1; render_x = 2'd1; render_y = 2'd1; render_data = 12'h123;
      step;
      checks++;
      if (fb_we !== 1'b0 || fb_swap !== 1'b0 || render_ready !== 1'b0) begin
        errors++;
        $display("FAIL wait_vb_gate[%0d] got we=%b swap=%b rdy=%b exp 0 0 0",
                 i, fb_we, fb_swap, render_ready);
      end
    end
    render_we = 1'b0;
    vblank_rd = 1'b1;
    n = 0;
    do begin step; n++; end while (fb_swap !== 1'b1 && n < 12);
    model_count = (model_count + 1) % 256;
    checks++;
    if (fb_swap !== 1'b1 || n < SS + 1 || n > SS + 2) begin
      errors++; $display("FAIL swap_latency got %0d swap=%b exp 3..4 swap=1", n, fb_swap);
    end
    checks++;
    if (frame_count !== 8'(model_count) || fb_we !== 1'b0 || render_ready !== 1'b0) begin
      errors++;
      $display("FAIL swap_state got cnt=%0d we=%b rdy=%b exp cnt=%0d we=0 rdy=0",
               frame_count, fb_we, render_ready, model_count);
    end
    fill_color = 12'hFF0;
`ifdef FB_CLEAR_EN
    for (int p = 0; p < W * H; p++) begin
      step;
      checks++;
      if ({fb_we, fb_x, fb_y, fb_data, fb_swap, render_ready} !==
          {1'b1, 2'(p % W), 2'(p / W), fill, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL clear_px[%0d] got we=%b (%0d,%0d) %h swap=%b rdy=%b exp we=1 (%0d,%0d) %h swap=0 rdy=0",
                 p, fb_we, fb_x, fb_y, fb_data, fb_swap, render_ready, p % W, p / W, fill);
      end
    end
`endif
    step;
    checks++;
    if (render_ready !== 1'b1 || fb_we !== 1'b0 || fb_swap !== 1'b0) begin
      errors++;
      $display("FAIL swap_done got rdy=%b we=%b swap=%b exp 1 0 0", render_ready, fb_we, fb_swap);
    end
  endtask

  task automatic test_vblank_high;
    int lat, rdy;
    bit seen;
    vblank_rd = 1'b1;
    repeat (SS + 2) step;
    render_done = 1'b1;
    step;
    for (int i = 0; i < 10; i++) begin
      render_done = (i == 3);
      render_we = 1'b1;
      render_x = 2'($urandom_range(0, W - 1));
      render_y = 2'($urandom_range(0, H - 1));
      step;
      checks++;
      if (fb_we !== 1'b0 || fb_swap !== 1'b0 || render_ready !== 1'b0) begin
        errors++;
        $display("FAIL vb_high_wait[%0d] got we=%b swap=%b rdy=%b exp 0 0 0",
                 i, fb_we, fb_swap, render_ready);
      end
    end
    render_we = 1'b0; render_done = 1'b0;
    complete_swap(lat, rdy);
    model_count = (model_count + 1) % 256;
    checks++;
    if (lat < SS + 1 || lat > SS + 2 || rdy != EXP_RDY || frame_count !== 8'(model_count)) begin
      errors++;
      $display("FAIL vb_high_swap got lat=%0d rdy=%0d cnt=%0d exp lat=3..4 rdy=%0d cnt=%0d",
               lat, rdy, frame_count, EXP_RDY, model_count);
    end
    // A done pulse issued during WAIT_VB must not have been queued.
    vblank_rd = 1'b0;
    repeat (SS + 2) step;
    vblank_rd = 1'b1;
    seen = 1'b0;
    repeat (8) begin step; if (fb_swap === 1'b1) seen = 1'b1; end
    checks++;
    if (seen || render_ready !== 1'b1) begin
      errors++; $display("FAIL done_no_queue got swap_seen=%b rdy=%b exp 0 1", seen, render_ready);
    end
  endtask

  task automatic test_coincident;
    int  lat, rdy;
    bit  seen;
    vblank_rd = 1'b0;
    repeat (SS + 2) step;
    vblank_rd = 1'b1;
    repeat (SS) step;
    render_done = 1'b1;
    step;
    render_done = 1'b0;
    seen = 1'b0;
    repeat (10) begin step; if (fb_swap === 1'b1) seen = 1'b1; end
    checks++;
    if (seen || render_ready !== 1'b0) begin
      errors++; $display("FAIL coincident_rise got swap_seen=%b rdy=%b exp 0 0", seen, render_ready);
    end
    complete_swap(lat, rdy);
    model_count = (model_count + 1) % 256;
    checks++;
    if (lat < SS + 1 || lat > SS + 2 || rdy != EXP_RDY || frame_count !== 8'(model_count)) begin
      errors++;
      $display("FAIL coincident_swap got lat=%0d rdy=%0d cnt=%0d exp lat=3..4 rdy=%0d cnt=%0d",
               lat, rdy, frame_count, EXP_RDY, model_count);
    end
  endtask

  task automatic test_done_with_write;
    int          lat, rdy;
    logic [11:0] d;
    d = 12'($urandom);
    render_we = 1'b1; render_x = 2'd3; render_y = 2'd2; render_data = d; render_done = 1'b1;
    step;
    render_done = 1'b0;
    checks++;
    if ({fb_we, fb_x, fb_y, fb_data, render_ready} !== {1'b1, 2'd3, 2'd2, d, 1'b0}) begin
      errors++;
      $display("FAIL done_write got we=%b (%0d,%0d) %h rdy=%b exp we=1 (3,2) %h rdy=0",
               fb_we, fb_x, fb_y, fb_data, render_ready, d);
    end
    render_x = 2'd1; render_y = 2'd1;
    step;
    render_we = 1'b0;
    checks++;
    if (fb_we !== 1'b0) begin
      errors++; $display("FAIL done_then_drop got we=%b exp 0", fb_we);
    end
    complete_swap(lat, rdy);
    model_count = (model_count + 1) % 256;
    checks++;
    if (lat < SS + 1 || lat > SS + 2 || rdy != EXP_RDY || frame_count !== 8'(model_count)) begin
      errors++;
      $display("FAIL done_write_swap got lat=%0d rdy=%0d cnt=%0d exp lat=3..4 rdy=%0d cnt=%0d",
               lat, rdy, frame_count, EXP_RDY, model_count);
    end
  endtask

  task automatic test_reset_mid;
`ifdef FB_CLEAR_EN
    int n;
`endif
    vblank_rd = 1'b0;
    repeat (SS + 2) step;
    render_done = 1'b1;
    step;
    render_done = 1'b0;
    repeat (3) step;
    rst = 1'b1;
    #1;
    checks++;
    if (w_outs !== RESET_VEC) begin
      errors++; $display("FAIL rst_wait_vb got %h exp %h", w_outs, RESET_VEC);
    end
    step;
    rst = 1'b0;
    model_count = 0;
    step;
    checks++;
    if (w_outs !== RESET_VEC) begin
      errors++; $display("FAIL rst_wait_vb_release got %h exp %h", w_outs, RESET_VEC);
    end
`ifdef FB_CLEAR_EN
    fill_color = 12'h3C3;
    render_done = 1'b1;
    step;
    render_done = 1'b0;
    vblank_rd = 1'b1;
    n = 0;
    do begin step; n++; end while (fb_swap !== 1'b1 && n < 12);
    checks++;
    if (fb_swap !== 1'b1) begin
      errors++; $display("FAIL rst_clr_swap got swap=%b exp 1", fb_swap);
    end
    repeat (6) step;
    checks++;
    if ({fb_we, fb_x, fb_y, fb_data} !== {1'b1, 2'd1, 2'd1, 12'h3C3}) begin
      errors++;
      $display("FAIL rst_clr_pixel5 got we=%b (%0d,%0d) %h exp we=1 (1,1) 3c3", fb_we, fb_x, fb_y, fb_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (w_outs !== RESET_VEC) begin
      errors++; $display("FAIL rst_mid_clear got %h exp %h", w_outs, RESET_VEC);
    end
    step;
    vblank_rd = 1'b0;
    rst = 1'b0;
    step;
    checks++;
    if (w_outs !== RESET_VEC) begin
      errors++; $display("FAIL rst_mid_clear_release got %h exp %h", w_outs, RESET_VEC);
    end
`endif
    render_we = 1'b1; render_x = 2'd1; render_y = 2'd2; render_data = 12'h5A5;
    step;
    render_we = 1'b0;
    checks++;
    if ({fb_we, fb_x, fb_y, fb_data, render_ready} !== {1'b1, 2'd1, 2'd2, 12'h5A5, 1'b1}) begin
      errors++;
      $display("FAIL rst_then_write got we=%b (%0d,%0d) %h rdy=%b exp we=1 (1,2) 5a5 rdy=1",
               fb_we, fb_x, fb_y, fb_data, render_ready);
    end
  endtask

  task automatic test_wrap;
    int lat, rdy;
    for (int s = 0; s < 256; s++) begin
      fill_color = 12'($urandom);
      render_done = 1'b1;
      step;
      render_done = 1'b0;
      complete_swap(lat, rdy);
      model_count = (model_count + 1) % 256;
      checks++;
      if (lat < SS + 1 || lat > SS + 2 || rdy != EXP_RDY || frame_count !== 8'(model_count)) begin
        errors++;
        $display("FAIL wrap[%0d] got lat=%0d rdy=%0d cnt=%0d exp lat=3..4 rdy=%0d cnt=%0d",
                 s, lat, rdy, frame_count, EXP_RDY, model_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_writes();
    test_swap();
    test_vblank_high();
    test_coincident();
    test_done_with_write();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
